// File: rtl/iserdes_pkg.sv
// Shared types and defaults for the ISERDES lane alignment controller.
package iserdes_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_TAP_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_TAP_NEXT,
        ST_CENTER,
        ST_SLIP,
        ST_SLIP_WAIT,
        ST_CHECK,
        ST_ALIGNED,
        ST_FAIL
    } state_t;

    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'h0A;
    localparam logic [7:0] DEF_IDLE_PATTERN  = 8'hFF;
    // An 8:1 deserialiser has 8 word phases; 8 slips without a match means no phase works.
    localparam int         SLIP_MAX          = 8;

endpackage

// File: rtl/iserdes_align_ctrl_if.sv
// Controller <-> ISERDESE2/IDELAYE2 primitive connection (parallel word in, tap/bitslip out).
interface iserdes_align_ctrl_if #(
    parameter int TAP_W = 5
);
    logic [7:0]       q;
    logic             bitslip;
    logic             dly_ld;
    logic [TAP_W-1:0] dly_tap;

    modport master (input q, output bitslip, output dly_ld, output dly_tap);
    modport slave  (output q, input bitslip, input dly_ld, input dly_tap);
endinterface

// File: rtl/eye_tracker.sv
// Tracks runs of consecutive good IDELAY taps during a sweep and keeps the widest one.
module eye_tracker #(
    parameter int TAP_W = 5
) (
    input  logic             clkdiv,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W-1:0] best_end,
    output logic [TAP_W:0]   best_width
);
    localparam int LEN_W = TAP_W + 1;

    logic             run_active_reg, run_active_next;
    logic [TAP_W-1:0] run_start_reg, run_start_next;
    logic [LEN_W-1:0] run_len_reg, run_len_next;
    logic [TAP_W-1:0] best_start_reg, best_start_next;
    logic [TAP_W-1:0] best_end_reg, best_end_next;
    logic [LEN_W-1:0] best_width_reg, best_width_next;

    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] close_len;
    logic [TAP_W-1:0] close_start;
    logic [TAP_W-1:0] close_end;
    logic             do_close;

    always_comb begin
        run_active_next = run_active_reg;
        run_start_next  = run_start_reg;
        run_len_next    = run_len_reg;
        best_start_next = best_start_reg;
        best_end_next   = best_end_reg;
        best_width_next = best_width_reg;
        cur_len         = run_active_reg ? run_len_reg + LEN_W'(1) : LEN_W'(1);
        close_start     = (good && !run_active_reg) ? tap : run_start_reg;
        close_len       = '0;
        close_end       = '0;
        do_close        = 1'b0;

        if (clear) begin
            run_active_next = 1'b0;
            run_start_next  = '0;
            run_len_next    = '0;
            best_start_next = '0;
            best_end_next   = '0;
            best_width_next = '0;
        end else if (valid) begin
            if (good) begin
                run_active_next = 1'b1;
                run_len_next    = cur_len;
                run_start_next  = close_start;
            end
            // The last tap closes an open run even when it is good.
            if (good && (&tap)) begin
                do_close  = 1'b1;
                close_len = cur_len;
                close_end = tap;
            end else if (!good && run_active_reg) begin
                do_close  = 1'b1;
                close_len = run_len_reg;
                close_end = tap - TAP_W'(1);
            end
            if (do_close) begin
                run_active_next = 1'b0;
                run_len_next    = '0;
                // Strictly wider only, so ties keep the lower-tap eye.
                if (close_len > best_width_reg) begin
                    best_start_next = close_start;
                    best_end_next   = close_end;
                    best_width_next = close_len;
                end
            end
        end
    end

    always_ff @(posedge clkdiv or negedge rst) begin
        if (!rst) begin
            run_active_reg <= 1'b0;
            run_start_reg  <= '0;
            run_len_reg    <= '0;
            best_start_reg <= '0;
            best_end_reg   <= '0;
            best_width_reg <= '0;
        end else begin
            run_active_reg <= run_active_next;
            run_start_reg  <= run_start_next;
            run_len_reg    <= run_len_next;
            best_start_reg <= best_start_next;
            best_end_reg   <= best_end_next;
            best_width_reg <= best_width_next;
        end
    end

    assign best_start = best_start_reg;
    assign best_end   = best_end_reg;
    assign best_width = best_width_reg;

endmodule

// File: rtl/iserdes_align_ctrl.sv
// Per-lane link training: IDELAY eye sweep, centre load, bitslip word alignment, loss monitor.
// Define ALIGN_MON_EN to enable the ALIGNED loss monitor with automatic retraining.
module iserdes_align_ctrl
    import iserdes_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter logic [7:0] IDLE_PATTERN  = DEF_IDLE_PATTERN,
    parameter int         TAP_W         = 5,
    parameter int         SETTLE_CYC    = 8,
    parameter int         STABLE_CNT    = 16,
    parameter int         MIN_EYE       = 4,
    parameter int         LOSS_CNT      = 32
) (
    input  logic                  clkdiv,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  locked_in,
    iserdes_align_ctrl_if.master  serdes,
    output logic                  aligned,
    output logic                  fail,
    output logic [TAP_W:0]        eye_width
);
    localparam int TMR_W  = $clog2(SETTLE_CYC + 1);
    localparam int STAB_W = $clog2(STABLE_CNT + 1);
    localparam int SLIP_W = $clog2(SLIP_MAX + 1);
    localparam logic [TAP_W-1:0] TAP_LAST = '1;

    state_t           state_reg, state_next;
    logic [TAP_W-1:0] tap_reg, tap_next;
    logic [TAP_W:0]   eye_width_reg, eye_width_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [STAB_W-1:0] stab_reg, stab_next;
    logic [SLIP_W-1:0] slip_reg, slip_next;
    logic             centred_reg, centred_next;
    logic             tap_good_reg, tap_good_next;
    logic [7:0]       q_prev_reg;
`ifdef ALIGN_MON_EN
    localparam int LOSS_W = $clog2(LOSS_CNT + 1);
    logic [LOSS_W-1:0] loss_reg, loss_next;
`endif

    logic             trk_clear;
    logic             trk_valid;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W-1:0] best_end;
    logic [TAP_W:0]   best_width;
    logic [TAP_W:0]   centre_sum;

    eye_tracker #(.TAP_W(TAP_W)) u_eye (
        .clkdiv     (clkdiv),
        .rst        (rst),
        .clear      (trk_clear),
        .valid      (trk_valid),
        .good       (tap_good_reg),
        .tap        (tap_reg),
        .best_start (best_start),
        .best_end   (best_end),
        .best_width (best_width)
    );

    assign centre_sum = {1'b0, best_start} + {1'b0, best_end};

    always_comb begin
        state_next     = state_reg;
        tap_next       = tap_reg;
        eye_width_next = eye_width_reg;
        tmr_next       = tmr_reg;
        stab_next      = stab_reg;
        slip_next      = slip_reg;
        centred_next   = centred_reg;
        tap_good_next  = tap_good_reg;
        trk_clear      = 1'b0;
        trk_valid      = 1'b0;
`ifdef ALIGN_MON_EN
        loss_next      = loss_reg;
`endif

        // Lost clock lock aborts whatever training step is in progress.
        if (!locked_in && state_reg != ST_IDLE && state_reg != ST_FAIL) begin
            state_next     = ST_WAIT_LOCK;
            tap_next       = '0;
            eye_width_next = '0;
            centred_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_in) begin
                        state_next   = ST_TAP_LOAD;
                        tap_next     = '0;
                        centred_next = 1'b0;
                        trk_clear    = 1'b1;
                    end
                end
                ST_TAP_LOAD: begin
                    state_next = ST_SETTLE;
                    tmr_next   = '0;
                end
                ST_SETTLE: begin
                    if (tmr_reg == TMR_W'(SETTLE_CYC - 1)) begin
                        state_next = centred_reg ? ST_CHECK : ST_SAMPLE;
                        stab_next  = '0;
                        slip_next  = '0;
                    end else begin
                        tmr_next = tmr_reg + TMR_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (serdes.q == q_prev_reg && serdes.q != IDLE_PATTERN) begin
                        if (stab_reg == STAB_W'(STABLE_CNT - 1)) begin
                            tap_good_next = 1'b1;
                            state_next    = ST_TAP_NEXT;
                        end else begin
                            stab_next = stab_reg + STAB_W'(1);
                        end
                    end else begin
                        tap_good_next = 1'b0;
                        state_next    = ST_TAP_NEXT;
                    end
                end
                ST_TAP_NEXT: begin
                    trk_valid = 1'b1;
                    if (tap_reg == TAP_LAST) begin
                        state_next = ST_CENTER;
                    end else begin
                        tap_next   = tap_reg + TAP_W'(1);
                        state_next = ST_TAP_LOAD;
                    end
                end
                ST_CENTER: begin
                    if (best_width < (TAP_W + 1)'(MIN_EYE)) begin
                        state_next = ST_FAIL;
                    end else begin
                        tap_next       = TAP_W'(centre_sum >> 1);
                        eye_width_next = best_width;
                        centred_next   = 1'b1;
                        state_next     = ST_TAP_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (serdes.q == TRAIN_PATTERN) begin
                        state_next = ST_ALIGNED;
`ifdef ALIGN_MON_EN
                        loss_next  = '0;
`endif
                    end else if (serdes.q == IDLE_PATTERN) begin
                        state_next = ST_CHECK;
                    end else if (slip_reg == SLIP_W'(SLIP_MAX)) begin
                        state_next = ST_FAIL;
                    end else begin
                        state_next = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    slip_next  = slip_reg + SLIP_W'(1);
                    tmr_next   = '0;
                    state_next = ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    if (tmr_reg == TMR_W'(SETTLE_CYC - 1)) begin
                        state_next = ST_CHECK;
                    end else begin
                        tmr_next = tmr_reg + TMR_W'(1);
                    end
                end
                ST_ALIGNED: begin
`ifdef ALIGN_MON_EN
                    if (serdes.q == TRAIN_PATTERN) begin
                        loss_next = '0;
                    end else if (serdes.q != IDLE_PATTERN) begin
                        if (loss_reg == LOSS_W'(LOSS_CNT - 1)) begin
                            state_next     = ST_WAIT_LOCK;
                            tap_next       = '0;
                            eye_width_next = '0;
                            centred_next   = 1'b0;
                        end else begin
                            loss_next = loss_reg + LOSS_W'(1);
                        end
                    end
`endif
                end
                ST_FAIL: begin
                    if (start) begin
                        state_next     = ST_WAIT_LOCK;
                        tap_next       = '0;
                        eye_width_next = '0;
                        centred_next   = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkdiv or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            tap_reg       <= '0;
            eye_width_reg <= '0;
            tmr_reg       <= '0;
            stab_reg      <= '0;
            slip_reg      <= '0;
            centred_reg   <= 1'b0;
            tap_good_reg  <= 1'b0;
            q_prev_reg    <= '0;
`ifdef ALIGN_MON_EN
            loss_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            tap_reg       <= tap_next;
            eye_width_reg <= eye_width_next;
            tmr_reg       <= tmr_next;
            stab_reg      <= stab_next;
            slip_reg      <= slip_next;
            centred_reg   <= centred_next;
            tap_good_reg  <= tap_good_next;
            q_prev_reg    <= serdes.q;
`ifdef ALIGN_MON_EN
            loss_reg      <= loss_next;
`endif
        end
    end

    // Strobes decode directly from state, so reset or lock loss can never leave one stuck high.
    assign serdes.dly_ld  = (state_reg == ST_TAP_LOAD);
    assign serdes.bitslip = (state_reg == ST_SLIP);
    assign serdes.dly_tap = tap_reg;
    assign aligned        = (state_reg == ST_ALIGNED);
    assign fail           = (state_reg == ST_FAIL);
    assign eye_width      = eye_width_reg;

endmodule

// File: tb/tb_iserdes_align_ctrl.sv
// Directed bench for iserdes_align_ctrl with a behavioural IDELAY/ISERDES lane model.
module tb_iserdes_align_ctrl;
    localparam int         TAP_W      = 5;
    localparam int         SETTLE_CYC = 8;
    localparam logic [7:0] TRAIN      = 8'h0A;

    logic             clkdiv;
    logic             rst;
    logic             start;
    logic             locked_in;
    logic             aligned;
    logic             fail;
    logic [TAP_W:0]   eye_width;

    iserdes_align_ctrl_if #(.TAP_W(TAP_W)) serdes ();

    iserdes_align_ctrl dut (
        .clkdiv    (clkdiv),
        .rst       (rst),
        .start     (start),
        .locked_in (locked_in),
        .serdes    (serdes),
        .aligned   (aligned),
        .fail      (fail),
        .eye_width (eye_width)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    // Lane model state
    logic [31:0] eye_mask;
    int          rot;
    bit          nomatch;
    bit          ovr_en;
    logic [7:0]  ovr_val;
    logic [7:0]  model_q;
    int          m_tap;
    int          m_slips;
    int          cyc;
    int          last_strobe;
    int          n_ld;
    int          n_slip;
    int          n_both;
    int          n_close;

    int n_tests;
    int n_fail;

    assign serdes.q = ovr_en ? ovr_val : model_q;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Good taps give a stable (possibly rotated) word; bad taps give a word that changes every cycle.
    always @(negedge clkdiv) begin
        cyc++;
        if (!rst) begin
            m_tap       = 0;
            m_slips     = 0;
            last_strobe = -1000;
        end else begin
            if (serdes.dly_ld || serdes.bitslip) begin
                if (serdes.dly_ld && serdes.bitslip) n_both++;
                if (cyc - last_strobe < SETTLE_CYC + 1) n_close++;
                last_strobe = cyc;
            end
            if (serdes.dly_ld) begin
                m_tap = int'(serdes.dly_tap);
                n_ld++;
            end
            if (serdes.bitslip) begin
                m_slips++;
                n_slip++;
            end
        end
        if (eye_mask[m_tap])
            model_q = rotl8(nomatch ? 8'h33 : TRAIN, rot + m_slips);
        else
            model_q = 8'(cyc) ^ 8'h5A;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // kind 0: any dly_ld, 1: bitslip, 2: aligned or fail
    task automatic wait_ev(input int kind, input int budget, input string tag,
                           output logic [TAP_W-1:0] tap_seen);
        bit hit;
        hit      = 1'b0;
        tap_seen = '0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clkdiv);
            case (kind)
                0:       hit = serdes.dly_ld;
                1:       hit = serdes.bitslip;
                default: hit = aligned || fail;
            endcase
            tap_seen = serdes.dly_tap;
        end
        check({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic wait_load_tap(input logic [TAP_W-1:0] want, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clkdiv);
            hit = serdes.dly_ld && (serdes.dly_tap == want);
        end
        check({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clkdiv);
        rst    = 1'b0;
        start  = 1'b0;
        ovr_en = 1'b0;
        repeat (3) @(negedge clkdiv);
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clkdiv);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] w, input int n);
        ovr_en  = 1'b1;
        ovr_val = w;
        repeat (n) @(negedge clkdiv);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAP_W-1:0] t;
        int slip_base;
        int ld_base;

        n_tests = 0; n_fail = 0;
        cyc = 0; n_ld = 0; n_slip = 0; n_both = 0; n_close = 0;
        m_tap = 0; m_slips = 0; last_strobe = -1000; model_q = 8'h00;
        rst = 1'b0; start = 1'b0; locked_in = 1'b1;
        eye_mask = '0; rot = 0; nomatch = 1'b0; ovr_en = 1'b0; ovr_val = 8'h00;

        repeat (3) @(negedge clkdiv);
        check("rst_bitslip", 32'(serdes.bitslip), 32'd0);
        check("rst_dly_ld",  32'(serdes.dly_ld),  32'd0);
        check("rst_dly_tap", 32'(serdes.dly_tap), 32'd0);
        check("rst_aligned", 32'(aligned),        32'd0);
        check("rst_fail",    32'(fail),           32'd0);
        check("rst_eye",     32'(eye_width),      32'd0);

        // Eye 10..19, word rotated by 3 -> centre 14, width 10, 5 slips
        eye_mask = span(10, 19); rot = 3;
        rst = 1'b1;
        slip_base = n_slip;
        pulse_start();
        wait_ev(2, 3000, "A_done", t);
        check("A_aligned", 32'(aligned),         32'd1);
        check("A_fail",    32'(fail),            32'd0);
        check("A_tap",     32'(serdes.dly_tap),  32'd14);
        check("A_eye",     32'(eye_width),       32'd10);
        check("A_slips",   32'(n_slip - slip_base), 32'd5);

        // 31 bad words (idle in between holds the count), then a match
        feed(8'h3C, 20);
        feed(8'hFF, 4);
        feed(8'h3C, 11);
        check("LM31_aligned", 32'(aligned), 32'd1);
        feed(TRAIN, 1);
        feed(8'h3C, 32);
`ifdef ALIGN_MON_EN
        check("LM32_aligned", 32'(aligned),        32'd0);
        check("LM32_tap",     32'(serdes.dly_tap), 32'd0);
        ovr_en = 1'b0;
        wait_ev(2, 3000, "LM_retrain", t);
        check("LM_re_aligned", 32'(aligned),        32'd1);
        check("LM_re_tap",     32'(serdes.dly_tap), 32'd14);
`else
        check("LM32_aligned", 32'(aligned),   32'd1);
        check("LM32_eye",     32'(eye_width), 32'd10);
        ovr_en = 1'b0;
`endif

        // Two eyes 2..5 and 20..27 -> wider one wins, centre 23
        eye_mask = span(2, 5) | span(20, 27); rot = 7;
        do_reset();
        slip_base = n_slip;
        pulse_start();
        wait_ev(2, 3000, "B_done", t);
        check("B_aligned", 32'(aligned),         32'd1);
        check("B_tap",     32'(serdes.dly_tap),  32'd23);
        check("B_eye",     32'(eye_width),       32'd8);
        check("B_slips",   32'(n_slip - slip_base), 32'd1);

        // Eye exactly MIN_EYE wide ending at the last tap -> centre 29
        eye_mask = span(28, 31); rot = 0;
        do_reset();
        pulse_start();
        wait_ev(2, 3000, "E4_done", t);
        check("E4_aligned", 32'(aligned),        32'd1);
        check("E4_tap",     32'(serdes.dly_tap), 32'd29);
        check("E4_eye",     32'(eye_width),      32'd4);

        // Eye too narrow -> fail, no slips; start restarts the sweep at tap 0
        eye_mask = span(7, 8); rot = 3;
        do_reset();
        slip_base = n_slip;
        pulse_start();
        wait_ev(2, 3000, "C_done", t);
        check("C_fail",    32'(fail),    32'd1);
        check("C_aligned", 32'(aligned), 32'd0);
        check("C_slips",   32'(n_slip - slip_base), 32'd0);
        eye_mask = span(10, 19);
        pulse_start();
        check("C_fail_clr", 32'(fail), 32'd0);
        wait_ev(0, 20, "C_first_ld", t);
        check("C_first_tap", 32'(t), 32'd0);
        wait_ev(2, 3000, "C_retrain", t);
        check("C_re_aligned", 32'(aligned), 32'd1);

        // Word never matches -> 8 slips then fail
        eye_mask = span(10, 19); rot = 0; nomatch = 1'b1;
        do_reset();
        slip_base = n_slip;
        pulse_start();
        wait_ev(2, 3000, "D_done", t);
        check("D_fail",  32'(fail),    32'd1);
        check("D_aligned", 32'(aligned), 32'd0);
        check("D_slips", 32'(n_slip - slip_base), 32'd8);
        nomatch = 1'b0;

        // Lock loss in the middle of sampling tap 12
        eye_mask = span(10, 19); rot = 3;
        do_reset();
        pulse_start();
        wait_load_tap(TAP_W'(12), 1000, "E_tap12");
        repeat (12) @(negedge clkdiv);
        locked_in = 1'b0;
        ld_base = n_ld;
        @(negedge clkdiv);
        check("E_lk_tap",     32'(serdes.dly_tap), 32'd0);
        check("E_lk_ld",      32'(serdes.dly_ld),  32'd0);
        check("E_lk_aligned", 32'(aligned),        32'd0);
        check("E_lk_fail",    32'(fail),           32'd0);
        repeat (20) @(negedge clkdiv);
        check("E_lk_hold_loads", 32'(n_ld - ld_base), 32'd0);
        locked_in = 1'b1;
        wait_ev(0, 20, "E_relock_ld", t);
        check("E_relock_tap", 32'(t), 32'd0);

        // Async reset in SLIP_WAIT
        wait_ev(1, 3000, "E_slip", t);
        repeat (3) @(negedge clkdiv);
        #2 rst = 1'b0;
        #1;
        check("R_tap",     32'(serdes.dly_tap), 32'd0);
        check("R_eye",     32'(eye_width),      32'd0);
        check("R_bitslip", 32'(serdes.bitslip), 32'd0);
        check("R_ld",      32'(serdes.dly_ld),  32'd0);
        check("R_aligned", 32'(aligned),        32'd0);
        check("R_fail",    32'(fail),           32'd0);
        repeat (3) @(negedge clkdiv);
        rst = 1'b1;
        ld_base = n_ld;
        repeat (30) @(negedge clkdiv);
        check("R_idle_loads", 32'(n_ld - ld_base), 32'd0);
        check("R_idle_aligned", 32'(aligned), 32'd0);

        check("strobe_overlap", 32'(n_both),  32'd0);
        check("strobe_spacing", 32'(n_close), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iserdes_align_ctrl.md
Name: iserdes_align_ctrl

Overview:
Per-lane link-training controller for the 8:1 ISERDESE2 receive path. Sweeps the IDELAYE2 tap (VAR_LOAD mode) to find the widest stable data eye, loads the eye centre, then issues BITSLIP pulses until the parallel word equals the training pattern. Declares the lane aligned, then monitors for loss of alignment and retrains automatically. Runs in the clkdiv domain between the ISERDES/IDELAY primitives and the link layer.

Parameters:
TRAIN_PATTERN, 8'h0A, word expected after word alignment
IDLE_PATTERN, 8'hFF, line-idle word; never counts as an error or as a match
TAP_W, 5, IDELAY tap width; taps 0..2**TAP_W-1
SETTLE_CYC, 8, clkdiv cycles waited after any tap load or bitslip before sampling
STABLE_CNT, 16, consecutive identical non-idle words needed to call a tap good
MIN_EYE, 4, minimum good-run width in taps; narrower means fail
LOSS_CNT, 32, consecutive bad words in ALIGNED that trigger retraining

Ports:
clkdiv  in  1  divided clock, same clock as ISERDES CLKDIV
rst  in  1  asynchronous active-low reset
start  in  1  level; begins training from IDLE, restarts from FAIL
locked_in  in  1  MMCM lock; training holds while low
q  in  8  ISERDES parallel word, q[7] = first bit received
bitslip  out  1  one-cycle pulse to ISERDES BITSLIP
dly_ld  out  1  one-cycle load strobe to IDELAYE2 LD
dly_tap  out  TAP_W  value for IDELAYE2 CNTVALUEIN, held between loads
aligned  out  1  lane trained and pattern locked
fail  out  1  training failed (no eye >= MIN_EYE, or 8 slips without match)
eye_width  out  TAP_W+1  width of the selected eye, valid when aligned

Behaviour:
- Reset (rst=0, async): state IDLE; bitslip=0, dly_ld=0, dly_tap=0, aligned=0, fail=0, eye_width=0; all counters 0.
- States: IDLE, WAIT_LOCK, TAP_LOAD, SETTLE, SAMPLE, TAP_NEXT, CENTER, SLIP, SLIP_WAIT, CHECK, ALIGNED, FAIL.
- IDLE: start=1 -> WAIT_LOCK. WAIT_LOCK: locked_in=1 -> TAP_LOAD with tap=0, run and best registers cleared.
- Whenever locked_in=0 in any state other than IDLE/FAIL: drop aligned, go to WAIT_LOCK next cycle.
- TAP_LOAD: dly_tap=tap, dly_ld=1 for exactly 1 cycle -> SETTLE. SETTLE: count SETTLE_CYC cycles -> SAMPLE.
- SAMPLE: compare q with q registered one cycle earlier. Equal and != IDLE_PATTERN increments stab_cnt; any other word ends the tap as bad. stab_cnt reaching STABLE_CNT ends the tap as good. Ending -> TAP_NEXT.
- TAP_NEXT: good tap extends the current run (run_start recorded on the first good tap). A bad tap, or the last tap, closes the run. A closed run strictly longer than best replaces best (ties keep the lower taps). Then tap+1 -> TAP_LOAD, or after tap=2**TAP_W-1 -> CENTER.
- CENTER: best width < MIN_EYE -> FAIL. Otherwise tap = (best_start+best_end)>>1, computed at TAP_W+1 bits and truncated; eye_width = best width; load via TAP_LOAD/SETTLE, then -> CHECK with slip_cnt=0.
- CHECK: q==TRAIN_PATTERN -> ALIGNED. q==IDLE_PATTERN -> stay. Otherwise -> SLIP.
- SLIP: bitslip=1 for 1 cycle, slip_cnt+1 -> SLIP_WAIT (SETTLE_CYC cycles) -> CHECK. If slip_cnt reaches 8 without a match -> FAIL.
- bitslip and dly_ld are never high in the same cycle; minimum spacing between strobes is SETTLE_CYC+1 cycles.
- ALIGNED: aligned=1. Words other than TRAIN_PATTERN and IDLE_PATTERN increment loss_cnt; a matching word clears it; an idle word holds it. loss_cnt==LOSS_CNT -> aligned=0, go to WAIT_LOCK (full retrain).
- FAIL: fail=1 and held; start=1 clears fail, then WAIT_LOCK. start is ignored in all other states.
- Asynchronous reset mid-sweep aborts immediately; dly_tap returns to 0 and no strobe is emitted.

Optional Feature:
ALIGN_MON_EN: defined -> ALIGNED loss monitor and auto-retrain as above. Not defined -> ALIGNED is terminal until rst or locked_in loss; loss_cnt logic is removed.

Decomposition:
- Shared package iserdes_pkg: state enum, TRAIN_PATTERN/IDLE_PATTERN defaults, SLIP_MAX=8.
- One sub-module, eye_tracker: takes tap index and good/bad-per-tap, outputs best_start/best_end/width (the run/best logic).
- The FSM, timers and strobes stay in the top module.

Test Plan:
- Model the eye as good for taps 10..19, with q rotated by 3 bits -> best=10..19, dly_tap=14, eye_width=10, exactly 5 bitslip pulses, aligned=1.
- Model two eyes, 2..5 and 20..27 -> centre tap 23, eye_width=8.
- Model only taps 7..8 good -> fail=1 after the sweep, no bitslip; pulse start -> fail clears and sweep restarts at tap 0.
- Pattern never matches after centring -> 8 bitslip pulses, then fail=1.
- In ALIGNED inject 31 bad words then 1 good word -> stays aligned. Inject 32 bad words -> aligned=0 and re-sweep (with ALIGN_MON_EN); without the macro -> stays aligned.
- Deassert locked_in mid-SAMPLE, and pull rst low mid-SLIP_WAIT -> WAIT_LOCK and IDLE respectively, with all outputs at reset values.
